// File: rtl/au_src_fmt_pkg.sv
// ----------------------------------------------------------------------------
// au_pkg
// Shared definitions for the audio source/format block:
//   - src_e       : equaliser source encoding (SRC_I2S = 0, SRC_ADC = 1)
//   - DIV_50M     : sys_clk cycles per sample for 40 kHz at 50 MHz
//   - DEB_CYC_50M : key debounce length at 50 MHz (4 ms)
//   - cnt_width() : bits needed to hold 0..max_val
// ----------------------------------------------------------------------------
package au_pkg;

    typedef enum logic {
        SRC_I2S = 1'b0,
        SRC_ADC = 1'b1
    } src_e;

    localparam int DIV_50M     = 1250;
    localparam int DEB_CYC_50M = 200000;

    // Width of a counter that must represent every value 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/au_src_fmt_if.sv
// ----------------------------------------------------------------------------
// au_src_fmt_if
// Groups the data/control signals of au_src_fmt.
//   key      : active-low keys, [0] = I2S, [1] = ADC
//   i2s_din  : signed I2S left-channel sample
//   adc_din  : unsigned (offset binary) parallel ADC sample
//   smp_stb  : one-cycle sample strobe
//   src_sel  : active source (0 = I2S, 1 = ADC)
//   eq_din   : signed equaliser input sample
//   filt_din : signed filtered sample, qualified by filt_vld
//   dac_dat  : DAC code
//   clip     : one-cycle saturation pulse
// Modports: master = environment side, slave = au_src_fmt side.
// ----------------------------------------------------------------------------
interface au_src_fmt_if #(
    parameter int DATA_W = 24,
    parameter int ADC_W  = 8,
    parameter int DAC_W  = 8
);
    logic        [1:0]        key;
    logic signed [DATA_W-1:0] i2s_din;
    logic        [ADC_W-1:0]  adc_din;
    logic                     smp_stb;
    logic                     src_sel;
    logic signed [DATA_W-1:0] eq_din;
    logic signed [DATA_W-1:0] filt_din;
    logic                     filt_vld;
    logic        [DAC_W-1:0]  dac_dat;
    logic                     clip;

    modport master (
        output key, i2s_din, adc_din, filt_din, filt_vld,
        input  smp_stb, src_sel, eq_din, dac_dat, clip
    );

    modport slave (
        input  key, i2s_din, adc_din, filt_din, filt_vld,
        output smp_stb, src_sel, eq_din, dac_dat, clip
    );
endinterface

// File: rtl/au_src_fmt_key_deb.sv
// ----------------------------------------------------------------------------
// au_key_deb
// Debounce for one active-low key. The counter increments while the key is
// low, clears while it is high and saturates at DEB_CYC. press pulses for one
// cycle, in the cycle the counter holds DEB_CYC for the first time, so a held
// key produces exactly one event.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   key_n : active-low key input (synchronous to clk)
//   press : one-cycle press event
// ----------------------------------------------------------------------------
module au_key_deb
    import au_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_50M
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int            CW      = cnt_width(DEB_CYC);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    always_comb begin
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (key_n) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
            // Registered so the event lines up with the counter at DEB_CYC.
            press_d = (cnt_d == CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/au_src_fmt.sv
// ----------------------------------------------------------------------------
// au_src_fmt
// Audio front/back-end formatter for the equaliser chain.
//   - Sample strobe: divides sys_clk by DIV, smp_stb is a registered pulse.
//   - Source select: two debounced keys drive a two-state FSM (I2S / ADC);
//     eq_din is loaded from the selected source only on the strobe edge.
//   - ADC expansion: offset binary -> two's complement, left-aligned.
//   - DAC path: filt_din >>> SHIFT, saturated to DAC_W signed, converted to
//     offset binary; clip pulses when saturation happens.
// Configuration macro: AU_FMT_DAC_INV_EN -> dac_dat (and its reset value)
//   is bitwise inverted, for DACs whose output voltage falls with code.
// Ports:
//   sys_clk : the only clock
//   sys_rst : asynchronous active-low reset
//   bus     : au_src_fmt_if slave modport (key, samples, strobe, DAC code)
// Constraints: ADC_W, DAC_W in 2..DATA_W; SHIFT < DATA_W; DIV >= 2;
//   DEB_CYC >= 1.
// ----------------------------------------------------------------------------
module au_src_fmt
    import au_pkg::*;
#(
    parameter int DATA_W  = 24,
    parameter int ADC_W   = 8,
    parameter int DAC_W   = 8,
    parameter int SHIFT   = 7,
    parameter int DIV     = DIV_50M,
    parameter int DEB_CYC = DEB_CYC_50M
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    au_src_fmt_if.slave     bus
);
    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int               CNT_W    = cnt_width(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    localparam logic [ADC_W-1:0] ADC_MSB  = {1'b1, {(ADC_W-1){1'b0}}};
    localparam logic [DAC_W-1:0] DAC_MSB  = {1'b1, {(DAC_W-1){1'b0}}};

    // Saturation bounds of a DAC_W-bit signed value, sign-extended to DATA_W.
    localparam logic signed [DATA_W-1:0] SAT_MAX =
        {{(DATA_W-DAC_W+1){1'b0}}, {(DAC_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN =
        {{(DATA_W-DAC_W+1){1'b1}}, {(DAC_W-1){1'b0}}};

`ifdef AU_FMT_DAC_INV_EN
    localparam logic [DAC_W-1:0] DAC_RST = ~DAC_MSB;
`else
    localparam logic [DAC_W-1:0] DAC_RST = DAC_MSB;
`endif

    // ------------------------------------------------------------------
    // Key debounce, one instance per key
    // ------------------------------------------------------------------
    logic [1:0] press;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_deb
            au_key_deb #(
                .DEB_CYC (DEB_CYC)
            ) u_deb (
                .clk   (sys_clk),
                .rst_n (sys_rst),
                .key_n (bus.key[gi]),
                .press (press[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]         cnt_q,  cnt_d;
    logic                     stb_q,  stb_d;
    src_e                     src_q,  src_d;
    logic signed [DATA_W-1:0] eq_q,   eq_d;
    logic        [DAC_W-1:0]  dac_q,  dac_d;
    logic                     clip_q, clip_d;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic        [ADC_W-1:0]  adc_tc;
    logic signed [DATA_W-1:0] adc_ext;
    logic signed [DATA_W-1:0] filt_shr;
    logic signed [DATA_W-1:0] filt_sat;
    logic                     sat_hi;
    logic                     sat_lo;
    logic        [DAC_W-1:0]  dac_code;

    // Offset binary to two's complement is an MSB flip; then left-align.
    assign adc_tc  = bus.adc_din ^ ADC_MSB;
    assign adc_ext = DATA_W'(adc_tc) << (DATA_W - ADC_W);

    assign filt_shr = $signed(bus.filt_din) >>> SHIFT;
    assign sat_hi   = (filt_shr > SAT_MAX);
    assign sat_lo   = (filt_shr < SAT_MIN);

    always_comb begin
        filt_sat = filt_shr;
        if (sat_hi) begin
            filt_sat = SAT_MAX;
        end else if (sat_lo) begin
            filt_sat = SAT_MIN;
        end
    end

`ifdef AU_FMT_DAC_INV_EN
    assign dac_code = ~(filt_sat[DAC_W-1:0] ^ DAC_MSB);
`else
    assign dac_code = filt_sat[DAC_W-1:0] ^ DAC_MSB;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        stb_d  = (cnt_q == CNT_LAST);

        // key[0] is checked first so it wins a simultaneous press.
        src_d = src_q;
        if (press[0]) begin
            src_d = SRC_I2S;
        end else if (press[1]) begin
            src_d = SRC_ADC;
        end

        // Loaded on the strobe-raising edge from the current source, so a
        // source change never lands mid-sample.
        eq_d = eq_q;
        if (cnt_q == CNT_LAST) begin
            eq_d = (src_q == SRC_ADC) ? adc_ext : bus.i2s_din;
        end

        dac_d  = dac_q;
        clip_d = 1'b0;
        if (bus.filt_vld) begin
            dac_d  = dac_code;
            clip_d = sat_hi | sat_lo;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            cnt_q  <= '0;
            stb_q  <= 1'b0;
            src_q  <= SRC_ADC;
            eq_q   <= '0;
            dac_q  <= DAC_RST;
            clip_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            stb_q  <= stb_d;
            src_q  <= src_d;
            eq_q   <= eq_d;
            dac_q  <= dac_d;
            clip_q <= clip_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.smp_stb = stb_q;
    assign bus.src_sel = src_q;
    assign bus.eq_din  = eq_q;
    assign bus.dac_dat = dac_q;
    assign bus.clip    = clip_q;

endmodule

// File: doc/au_src_fmt.md
# au_src_fmt

Parametrised audio front/back-end formatter for the equaliser chain. It generates the sample-rate strobe from `sys_clk` and selects the equaliser input between the I2S left channel and the expanded parallel ADC word, using debounced keys. It also converts filtered signed samples into a saturated, offset-binary DAC code. It replaces the fixed-width divider, mode latch and slice-and-offset DAC logic with a width-generic, clipping-safe block on a single clock domain.

## Interface
Parameters:
- `DATA_W`, 24, signed sample width of I2S input, equaliser input and filter output
- `ADC_W`, 8, unsigned parallel ADC width; must be ≤ `DATA_W`
- `DAC_W`, 8, DAC code width; must be ≤ `DATA_W`
- `SHIFT`, 7, arithmetic right shift applied to the filter output before saturation; must be < `DATA_W`
- `DIV`, 1250, `sys_clk` cycles per sample (40 kHz at 50 MHz); ≥ 2
- `DEB_CYC`, 200000, consecutive low cycles before a key press is accepted; ≥ 1

Ports:
- `sys_clk`  in  1  system clock; the only clock
- `sys_rst`  in  1  asynchronous, active-low reset
- `key`  in  2  active-low keys: [0] selects I2S, [1] selects ADC
- `i2s_din`  in  DATA_W  signed I2S left-channel sample, quasi-static between strobes
- `adc_din`  in  ADC_W  unsigned ADC sample
- `smp_stb`  out  1  one-cycle sample strobe, period `DIV`
- `src_sel`  out  1  active source: 0 = I2S, 1 = ADC
- `eq_din`  out  DATA_W  signed equaliser input sample
- `filt_din`  in  DATA_W  signed filtered sample
- `filt_vld`  in  1  `filt_din` valid qualifier
- `dac_dat`  out  DAC_W  DAC code
- `clip`  out  1  one-cycle pulse when a saturation occurs

## Operation
- Divider `cnt` counts 0..DIV-1 and wraps. `smp_stb` is registered and goes high in the cycle after `cnt == DIV-1`.
- ADC expansion: invert the MSB of `adc_din` (offset binary to two's complement), then left-align it as `{x, (DATA_W-ADC_W)'0}`.
- Debounce runs per key. Each key has a counter that increments while the key is low and clears to 0 while it is high. The counter saturates at `DEB_CYC`. A press event fires once, in the cycle the counter reaches `DEB_CYC`.
- Source FSM has two states, `SRC_I2S` and `SRC_ADC`:
  - A key[0] event goes to `SRC_I2S`; a key[1] event goes to `SRC_ADC`.
  - If both events fire in the same cycle, key[0] wins.
  - A held key does not re-trigger.
  - `src_sel` reflects the state.
- `eq_din` is loaded from the selected source on the same edge that raises `smp_stb`. A source change therefore takes effect at the next strobe and never mid-sample.
- Output path, in the cycle `filt_vld` is high:
  - `s = filt_din >>> SHIFT`.
  - If `s` exceeds the DAC_W signed range, clamp it to +2^(DAC_W-1)-1 or -2^(DAC_W-1) and pulse `clip`.
  - `dac_dat` takes the clamped value with its MSB inverted (offset binary).
  - With `filt_vld` low, `dac_dat` holds its value and `clip` is 0.

## Timing
- Reset values: `cnt` = 0, `smp_stb` = 0, `src_sel` = 1 (ADC), `eq_din` = 0, `clip` = 0, debounce counters = 0, `dac_dat` = midscale.
  - Midscale is 2^(DAC_W-1), or 2^(DAC_W-1)-1 when the DAC inversion macro is enabled.
- First `smp_stb` after reset release: cycle `DIV`, counting the first active edge as cycle 1.
- `filt_din` to `dac_dat`: 1 cycle.
- A key low for exactly `DEB_CYC` cycles is accepted. `src_sel` updates 1 cycle after the counter reaches `DEB_CYC`.
- Reset mid-operation clears everything immediately. The debounce counters restart, so a key already held during reset needs a fresh `DEB_CYC` of low time.

## Configuration
- `AU_FMT_DAC_INV_EN` defined:
  - `dac_dat` is the bitwise inverse of the offset-binary code (full-scale positive gives 0, full-scale negative gives 2^DAC_W-1). This suits boards whose DAC voltage falls with code.
  - The reset value is the inverted midscale.
- Undefined: `dac_dat` is plain offset binary.

## Structure
- Package `au_pkg`: source encodings `SRC_I2S` and `SRC_ADC`, and `DIV`/`DEB_CYC` default constants for a 50 MHz clock.
- Sub-module `au_key_deb` holds one key's debounce counter and press-event output, and is instantiated twice.

## Test plan
Defaults apply unless stated; the bench overrides `DEB_CYC` = 4 and `DIV` = 10.
- Reset release, no keys pressed:
  - `smp_stb` pulses at cycles 10, 20, 30.
  - `src_sel` = 1.
  - With `adc_din` = 8'h80, `eq_din` = 0; with `adc_din` = 8'hFF, `eq_din` = 24'h7F0000.
- key[0] low for 3 cycles, then high: no source change. key[0] low for 4 cycles: `src_sel` goes to 0, and the next strobe loads `eq_din` = `i2s_din` (24'h123456).
- key[0] and key[1] reach `DEB_CYC` in the same cycle: `src_sel` = 0. With both keys held for 50 cycles, no further transitions occur.
- Output formatting:
  - `filt_din` = 24'h003F80 with `filt_vld`: `dac_dat` = 8'hFF, `clip` = 0.
  - `filt_din` = 24'h004000: `dac_dat` = 8'hFF, `clip` = 1.
  - `filt_din` = 24'hFFC000: `dac_dat` = 8'h00, `clip` = 0.
  - `filt_din` = 0: `dac_dat` = 8'h80.
- With `AU_FMT_DAC_INV_EN` defined, repeat the previous scenario: results are 8'h00, 8'h00, 8'hFF, 8'h7F, and the reset value is 8'h7F.
- Assert reset mid-count (`cnt` = 5, `src_sel` = 0): all outputs return to their reset values immediately, and the first strobe follows 10 cycles after release.
